// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//   Car-park entry controller: gate FSM with two-digit password check,
//   occupancy counter, wrong-password lockout and a two-digit 7-segment
//   display of free spaces. Entry is refused while the car park is full.
//
// Optional feature (compile-time macro PARKING_TIMEOUT_EN):
//   defined     - in WAIT_PASSWORD / WRONG_PASS, sensor_entrance low for
//                 WAIT_CYCLES consecutive cycles returns to IDLE (try count kept).
//   not defined - those states wait indefinitely and ignore sensor_entrance.
//
// Ports
//   clk              rising-edge system clock
//   reset_n          synchronous active-low reset
//   sensor_entrance  car present at the entrance
//   sensor_exit      car has passed the gate (completes an entry)
//   car_leave        one-cycle pulse, a car left the car park
//   password_1/2     keypad digits (PW_W bits each)
//   GREEN_LED        gate open
//   RED_LED          gate closed / refusal (blinks on wrong password)
//   HEX_1 / HEX_2    tens / units of free spaces, active-low {g,f,e,d,c,b,a}
//   occupancy        cars currently inside
//   full             occupancy == CAPACITY (combinational)
//   locked           wrong-password lockout active
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int unsigned     CAPACITY    = 20,
    parameter int unsigned     PW_W        = 2,
    parameter logic [PW_W-1:0] PASS_1      = 2'b01,
    parameter logic [PW_W-1:0] PASS_2      = 2'b10,
    parameter int unsigned     MAX_TRIES   = 3,
    parameter int unsigned     LOCK_CYCLES = 16,
    parameter int unsigned     WAIT_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sensor_entrance,
    input  logic            sensor_exit,
    input  logic            car_leave,
    input  logic [PW_W-1:0] password_1,
    input  logic [PW_W-1:0] password_2,
    output logic            GREEN_LED,
    output logic            RED_LED,
    output logic [6:0]      HEX_1,
    output logic [6:0]      HEX_2,
    output logic [6:0]      occupancy,
    output logic            full,
    output logic            locked
);

    localparam int unsigned OCC_W = 7;
    localparam int unsigned TMAX  = (LOCK_CYCLES > WAIT_CYCLES) ? LOCK_CYCLES : WAIT_CYCLES;
    localparam int unsigned TMR_W = $clog2(TMAX + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4,
        LOCKED        = 3'd5,
        FULL_HOLD     = 3'd6
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [TMR_W-1:0] timer;
    logic [TRY_W-1:0] try_cnt;
    logic             pw_ok;
    logic             wait_done;
    logic             lock_done;
    logic             try_last;
    logic             leave_ok;
    logic             timeout;
    logic             entry_done;
    logic             try_clr;
    logic             try_inc;
    logic             inc;
    logic [OCC_W-1:0] free_cnt;

    // Active-low 7-segment encoding {g,f,e,d,c,b,a}; non-digits blank.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    assign pw_ok     = (password_1 == PASS_1) && (password_2 == PASS_2);
    assign wait_done = (timer == TMR_W'(WAIT_CYCLES - 1));
    assign lock_done = (timer == TMR_W'(LOCK_CYCLES - 1));
    assign try_last  = (try_cnt == TRY_W'(MAX_TRIES - 1));
    assign full      = (occupancy == OCC_W'(CAPACITY));
    assign leave_ok  = car_leave && (occupancy != '0);
    assign inc       = entry_done && !full;
    assign free_cnt  = OCC_W'(CAPACITY) - occupancy;

`ifdef PARKING_TIMEOUT_EN
    // Counts consecutive cycles with no car at the entrance while waiting for a password.
    logic [TMR_W-1:0] away_cnt;
    logic             in_wait;

    assign in_wait = (state == WAIT_PASSWORD) || (state == WRONG_PASS);
    assign timeout = in_wait && !sensor_entrance && (away_cnt == TMR_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || !in_wait || sensor_entrance || timeout) begin
            away_cnt <= '0;
        end else begin
            away_cnt <= away_cnt + TMR_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state decision; a wrong password left standing in WRONG_PASS is
    // counted again every WAIT_CYCLES, which is what eventually locks out.
    always_comb begin
        nxt        = state;
        try_clr    = 1'b0;
        try_inc    = 1'b0;
        entry_done = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_entrance) begin
                    nxt = full ? FULL_HOLD : WAIT_PASSWORD;
                end
            end
            WAIT_PASSWORD: begin
                if (timeout) begin
                    nxt = IDLE;
                end else if (wait_done) begin
                    if (pw_ok) begin
                        nxt     = RIGHT_PASS;
                        try_clr = 1'b1;
                    end else begin
                        try_inc = 1'b1;
                        nxt     = try_last ? LOCKED : WRONG_PASS;
                    end
                end
            end
            WRONG_PASS: begin
                if (timeout) begin
                    nxt = IDLE;
                end else if (pw_ok) begin
                    nxt     = RIGHT_PASS;
                    try_clr = 1'b1;
                end else if (wait_done) begin
                    try_inc = 1'b1;
                    if (try_last) begin
                        nxt = LOCKED;
                    end
                end
            end
            RIGHT_PASS: begin
                if (sensor_exit) begin
                    entry_done = 1'b1;
                    nxt        = sensor_entrance ? STOP : IDLE;
                end
            end
            STOP: begin
                if (pw_ok) begin
                    nxt = RIGHT_PASS;
                end
            end
            LOCKED: begin
                if (lock_done) begin
                    nxt     = IDLE;
                    try_clr = 1'b1;
                end
            end
            FULL_HOLD: begin
                if (!sensor_entrance) begin
                    nxt = IDLE;
                end else if (leave_ok) begin
                    nxt = WAIT_PASSWORD;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, timers and Moore outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            try_cnt   <= '0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state) begin
                timer <= '0;
            end else if ((state == WRONG_PASS) && wait_done) begin
                timer <= '0;
            end else if ((state == WAIT_PASSWORD) || (state == WRONG_PASS) || (state == LOCKED)) begin
                timer <= timer + TMR_W'(1);
            end

            if (try_clr) begin
                try_cnt <= '0;
            end else if (try_inc) begin
                try_cnt <= try_cnt + TRY_W'(1);
            end

            GREEN_LED <= (nxt == RIGHT_PASS);
            locked    <= (nxt == LOCKED);
            if (nxt == WRONG_PASS) begin
                RED_LED <= ~RED_LED;
            end else begin
                RED_LED <= (nxt != IDLE) && (nxt != RIGHT_PASS);
            end
        end
    end

    // Occupancy: simultaneous entry and departure cancel; saturates at both ends.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (inc && !leave_ok) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (leave_ok && !inc) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    // Free-space display, one cycle behind occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            HEX_1 <= seg(4'(CAPACITY / 10));
            HEX_2 <= seg(4'(CAPACITY % 10));
        end else begin
            HEX_1 <= seg(4'(free_cnt / OCC_W'(10)));
            HEX_2 <= seg(4'(free_cnt % OCC_W'(10)));
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_ctrl
//   Table-driven bench: a list of {inputs, hold cycles, expected outputs}
//   records is built up front, each record's expectation is queued when its
//   stimulus is driven and popped for comparison after its last clock edge.
// ---------------------------------------------------------------------------
module tb_parking_gate_ctrl;

    localparam int CAP = 20;
    localparam int W   = 8;
    localparam int LK  = 16;
    localparam int OK1 = 1;
    localparam int OK2 = 2;
    localparam int BAD = 0;

    // Check-mask bits
    localparam int C_G = 1;
    localparam int C_R = 2;
    localparam int C_O = 4;
    localparam int C_L = 8;
    localparam int C_F = 16;
    localparam int C_H = 32;

    typedef struct {
        int rst;
        int ent;
        int ext;
        int lv;
        int p1;
        int p2;
        int n;
        int chk;
        int green;
        int red;
        int lock;
        int occ;
        int free;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic       car_leave;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;
    logic [6:0] occupancy;
    logic       full;
    logic       locked;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    int         occ_m;
    int         total;
    int         passed;
    logic [6:0] seg_tbl [10];

    parking_gate_ctrl #(
        .CAPACITY   (CAP),
        .PW_W       (2),
        .PASS_1     (2'b01),
        .PASS_2     (2'b10),
        .MAX_TRIES  (3),
        .LOCK_CYCLES(LK),
        .WAIT_CYCLES(W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .car_leave      (car_leave),
        .password_1     (password_1),
        .password_2     (password_2),
        .GREEN_LED      (GREEN_LED),
        .RED_LED        (RED_LED),
        .HEX_1          (HEX_1),
        .HEX_2          (HEX_2),
        .occupancy      (occupancy),
        .full           (full),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(int rst, int ent, int ext, int lv, int p1, int p2, int n,
                                    int chk, int green, int red, int lock, int occ, int free);
        vec_t v;
        v.rst = rst; v.ent = ent; v.ext = ext; v.lv = lv; v.p1 = p1; v.p2 = p2; v.n = n;
        v.chk = chk; v.green = green; v.red = red; v.lock = lock; v.occ = occ; v.free = free;
        vecs.push_back(v);
    endfunction

    // One complete valid entry from IDLE: wait, open, drive through.
    function automatic void enter_car();
        add_vec(0, 1, 0, 0, OK1, OK2, W + 1, C_G | C_R, 1, 0, 0, 0, 0);
        occ_m++;
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_G | C_R | C_O | C_F, 0, 0, 0, occ_m, 0);
    endfunction

    task automatic check(input int idx, input string what, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, what, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;

        seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
        seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
        seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
        total = 0;
        passed = 0;
        reset_n = 1'b0; sensor_entrance = 1'b0; sensor_exit = 1'b0; car_leave = 1'b0;
        password_1 = 2'b00; password_2 = 2'b00;

        // Reset and a first valid entry with its timing
        occ_m = 0;
        add_vec(1, 0, 0, 0, BAD, BAD, 2, C_G | C_R | C_O | C_L | C_F | C_H, 0, 0, 0, 0, CAP);
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_G | C_R, 0, 1, 0, 0, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, W - 1, C_G | C_R | C_L, 0, 1, 0, 0, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_G | C_R, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_G | C_R | C_O | C_H, 0, 0, 0, 1, CAP);
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_O | C_H, 0, 0, 0, 1, CAP - 1);
        occ_m = 1;

        // Fill to capacity, then refuse
        for (int k = 2; k <= CAP; k++) enter_car();
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_O | C_F | C_H, 0, 0, 0, CAP, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_G | C_R | C_O | C_F, 0, 1, 0, CAP, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, 3, C_R | C_O, 0, 1, 0, CAP, 0);

        // Departure while held at a full car park admits the waiting car
        add_vec(0, 1, 0, 1, OK1, OK2, 1, C_G | C_R | C_O | C_F, 0, 1, 0, CAP - 1, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, W, C_G | C_R, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_O | C_F, 0, 0, 0, CAP, 0);
        add_vec(0, 0, 0, 1, OK1, OK2, 1, C_O | C_H, 0, 0, 0, CAP - 1, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, W + 1, C_G | C_H, 1, 0, 0, 0, 1);

        // Reset while the gate is open
        add_vec(1, 0, 0, 0, OK1, OK2, 1, C_G | C_R | C_O | C_L | C_H, 0, 0, 0, 0, CAP);
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_G | C_R | C_O | C_H, 0, 0, 0, 0, CAP);
        occ_m = 0;

        // Three wrong checks lock out; correct password ignored while locked
        add_vec(0, 1, 0, 0, BAD, BAD, W + 1, C_G | C_R | C_L, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, BAD, BAD, 1, C_R, 0, 1, 0, 0, 0);
        add_vec(0, 1, 0, 0, BAD, BAD, 1, C_R, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, BAD, BAD, 2 * W - 3, C_G | C_R | C_L, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, BAD, BAD, 1, C_G | C_R | C_L, 0, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, OK1, OK2, LK - 1, C_G | C_R | C_L, 0, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_G | C_R | C_L, 0, 0, 0, 0, 0);

        // Try counter was cleared: one wrong check no longer locks
        add_vec(0, 1, 0, 0, BAD, BAD, W + 1, C_G | C_R | C_L, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_G | C_R, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_O, 0, 0, 0, 1, 0);
        occ_m = 1;

        // Tailgater: both cars counted, second one held until it keys in
        add_vec(0, 1, 0, 0, OK1, OK2, W + 1, C_G, 1, 0, 0, 0, 0);
        add_vec(0, 1, 1, 0, BAD, BAD, 1, C_G | C_R | C_O, 0, 1, 0, 2, 0);
        add_vec(0, 1, 0, 0, BAD, BAD, 2, C_R | C_O, 0, 1, 0, 2, 0);
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_G | C_R, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_O, 0, 0, 0, 3, 0);
        occ_m = 3;
        enter_car();
        enter_car();

        // Entry and departure on the same edge, then departure at zero
        add_vec(0, 1, 0, 0, OK1, OK2, W + 1, C_G, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1, OK1, OK2, 1, C_G | C_O, 0, 0, 0, 5, 0);
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_O | C_H, 0, 0, 0, 5, CAP - 5);
        add_vec(0, 0, 0, 1, OK1, OK2, 1, C_O, 0, 0, 0, 4, 0);
        add_vec(1, 0, 0, 0, OK1, OK2, 1, C_O, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1, OK1, OK2, 1, C_O | C_H, 0, 0, 0, 0, CAP);

        // Car drives away during the password wait
        add_vec(0, 1, 0, 0, OK1, OK2, 1, C_R, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, OK1, OK2, W - 1, C_G | C_R, 0, 1, 0, 0, 0);
`ifdef PARKING_TIMEOUT_EN
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_G | C_R | C_O, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, OK1, OK2, 3, C_G | C_R, 0, 0, 0, 0, 0);
`else
        add_vec(0, 0, 0, 0, OK1, OK2, 1, C_G | C_R, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, OK1, OK2, 1, C_O, 0, 0, 0, 1, 0);
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            v = vecs[i];
            reset_n         = (v.rst == 0);
            sensor_entrance = (v.ent != 0);
            sensor_exit     = (v.ext != 0);
            car_leave       = (v.lv != 0);
            password_1      = 2'(v.p1);
            password_2      = 2'(v.p2);
            exp_q.push_back(v);
            repeat (v.n) @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ((e.chk & C_G) != 0) check(i, "green", int'(GREEN_LED), e.green);
            if ((e.chk & C_R) != 0) check(i, "red", int'(RED_LED), e.red);
            if ((e.chk & C_L) != 0) check(i, "locked", int'(locked), e.lock);
            if ((e.chk & C_O) != 0) check(i, "occupancy", int'(occupancy), e.occ);
            if ((e.chk & C_F) != 0) check(i, "full", int'(full), (e.occ == CAP) ? 1 : 0);
            if ((e.chk & C_H) != 0) begin
                check(i, "hex1", int'(HEX_1), int'(seg_tbl[e.free / 10]));
                check(i, "hex2", int'(HEX_2), int'(seg_tbl[e.free % 10]));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
